// File: rtl/alu_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : alu_mc_if                                                    |
// | Purpose   : Operand/op request channel and result response channel of    |
// |             the multi-cycle ALU, each with its own valid/ready handshake.|
// | Signals   : a, b, alu_control, in_valid -> ALU ; in_ready <- ALU         |
// |             result, zero, out_valid <- ALU   ; out_ready -> ALU          |
// | Modports  : master (execute stage side), slave (ALU side)                |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, alu_control, in_valid, out_ready,
    input  in_ready, result, zero, out_valid
  );

  modport slave (
    input  a, b, alu_control, in_valid, out_ready,
    output in_ready, result, zero, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_mc                                                        |
// | Purpose  : Parametrised ALU with registered result and zero flag.        |
// |            Codes 0-9 (and 14/15 as ADD) complete in one cycle; MUL,      |
// |            MULHU, DIVU, REMU iterate one bit per cycle (WIDTH cycles).   |
// | Ports    : clk  - rising-edge clock                                      |
// |            rst  - asynchronous active-high reset                         |
// |            bus  - alu_mc_if.slave: request (a, b, alu_control, in_valid/ |
// |                   in_ready) and response (result, zero, out_valid/       |
// |                   out_ready)                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_mc_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;
  logic [1:0]       mop_q;       // 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;        // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] opnd_q;      // multiplicand / divisor

  logic             accept;
  logic             is_multi;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] fin_res;

  // Ready never looks at in_valid; held low while reset is applied.
  assign bus.in_ready  = !rst && ((state_q == S_IDLE) ||
                                  ((state_q == S_DONE) && bus.out_ready));
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_multi = (bus.alu_control >= 4'd10) && (bus.alu_control <= 4'd13);
  assign shamt    = bus.b[SHW-1:0];

  always_comb begin
    alu_res = bus.a + bus.b;
    case (bus.alu_control)
      4'd1:    alu_res = bus.a - bus.b;
      4'd2:    alu_res = bus.a & bus.b;
      4'd3:    alu_res = bus.a | bus.b;
      4'd4:    alu_res = bus.a ^ bus.b;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'd7:    alu_res = bus.a << shamt;
      4'd8:    alu_res = bus.a >> shamt;
      4'd9:    alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = bus.a + bus.b;
    endcase
  end

  // One iteration of shift-add multiply and of restoring divide.
  // Divisor zero needs no special case: every trial subtraction succeeds,
  // giving an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = !div_diff[WIDTH];
    if (mop_q[1]) begin
      acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    fin_res = mop_q[0] ? acc_d : lo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mop_q       <= 2'd0;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q    <= fin_res;
            zero_q      <= (fin_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        default: begin
          // IDLE, or DONE with the consumer taking the result.
          if (accept) begin
            if (is_multi) begin
              mop_q       <= 2'(bus.alu_control - 4'd10);
              acc_q       <= '0;
              lo_q        <= bus.a;
              opnd_q      <= bus.b;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= S_BUSY;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end else if ((state_q == S_IDLE) || bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_mc                                                     |
// | Purpose  : Directed testbench for alu_mc at WIDTH=32 and WIDTH=8.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_mc;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_mc_if #(.WIDTH(32)) bus32 ();
  alu_mc_if #(.WIDTH(8))  bus8 ();

  alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input bit w8);
    return w8 ? bus8.out_valid : bus32.out_valid;
  endfunction

  function automatic logic rdy(input bit w8);
    return w8 ? bus8.in_ready : bus32.in_ready;
  endfunction

  function automatic logic [31:0] res(input bit w8);
    return w8 ? {24'd0, bus8.result} : bus32.result;
  endfunction

  function automatic logic zr(input bit w8);
    return w8 ? bus8.zero : bus32.zero;
  endfunction

  task automatic drv(input bit w8, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic v);
    if (w8) begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.alu_control = op; bus8.in_valid = v;
    end else begin
      bus32.a = a; bus32.b = b; bus32.alu_control = op; bus32.in_valid = v;
    end
  endtask

  // Issue one op from IDLE, wait (bounded) for the result, check it, consume it.
  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input bit toggle_a);
    int lat;
    bit rdy_low;
    drv(w8, op, a, b, 1'b1);
    chk({tag, " in_ready"}, 64'(rdy(w8)), 64'd1);
    @(posedge clk); #1;
    drv(w8, op, a, b, 1'b0);
    lat = 0;
    rdy_low = 1'b1;
    while (!ov(w8) && lat < 200) begin
      if (rdy(w8)) rdy_low = 1'b0;
      if (toggle_a) begin
        if (w8) bus8.a = 8'($urandom()); else bus32.a = $urandom();
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(res(w8)), 64'(exp_res));
    chk({tag, " zero"}, 64'(zr(w8)), 64'(exp_res == 32'd0));
    if (exp_lat > 0) chk({tag, " in_ready low while busy"}, 64'(rdy_low), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    drv(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    drv(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    bus32.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(bus32.in_ready), 64'd0);
    chk("reset out_valid", 64'(bus32.out_valid), 64'd0);
    chk("reset result", 64'(bus32.result), 64'd0);
    chk("reset zero", 64'(bus32.zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset in_ready", 64'(bus32.in_ready), 64'd1);

    // Single-cycle operations
    run_op("ADD", 1'b0, 4'd0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1'b0);
    run_op("SUB", 1'b0, 4'd1, 32'd5, 32'd5, 0, 32'd0, 1'b0);
    run_op("XOR", 1'b0, 4'd4, 32'hF0F0_1234, 32'h0FF0_1234, 0, 32'hFF00_0000, 1'b0);
    run_op("SLT", 1'b0, 4'd5, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 1'b0);
    run_op("SLTU", 1'b0, 4'd6, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b0);
    run_op("SLL", 1'b0, 4'd7, 32'd1, 32'h21, 0, 32'd2, 1'b0);
    run_op("SRL", 1'b0, 4'd8, 32'h80000000, 32'd31, 0, 32'd1, 1'b0);
    run_op("SRA", 1'b0, 4'd9, 32'h80000000, 32'h24, 0, 32'hF8000000, 1'b0);
    run_op("OP14", 1'b0, 4'd14, 32'd2, 32'd3, 0, 32'd5, 1'b0);
    run_op("OP15", 1'b0, 4'd15, 32'd2, 32'd3, 0, 32'd5, 1'b0);

    // Multi-cycle operations
    run_op("MUL", 1'b0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, 1'b0);
    run_op("MULHU", 1'b0, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 1'b0);
    run_op("MUL small", 1'b0, 4'd10, 32'd1234, 32'd5678, 32, 32'd7006652, 1'b0);
    run_op("DIVU", 1'b0, 4'd12, 32'd100, 32'd7, 32, 32'd14, 1'b0);
    run_op("REMU", 1'b0, 4'd13, 32'd100, 32'd7, 32, 32'd2, 1'b0);
    run_op("DIVU by 0", 1'b0, 4'd12, 32'hDEADBEEF, 32'd0, 32, 32'hFFFFFFFF, 1'b0);
    run_op("REMU by 0", 1'b0, 4'd13, 32'h1234, 32'd0, 32, 32'h1234, 1'b0);
    run_op("DIVU toggle a", 1'b0, 4'd12, 32'd100, 32'd7, 32, 32'd14, 1'b1);

    // Backpressure: result held for 5 cycles in DONE
    bus32.out_ready = 1'b0;
    drv(1'b0, 4'd0, 32'd3, 32'd4, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 4'd0, 32'd9, 32'd9, 1'b0);
    chk("bp out_valid", 64'(bus32.out_valid), 64'd1);
    chk("bp result", 64'(bus32.result), 64'd7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold result", 64'(bus32.result), 64'd7);
      chk("bp in_ready low", 64'(bus32.in_ready), 64'd0);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released out_valid", 64'(bus32.out_valid), 64'd0);

    // Back-to-back stream: ADD, AND, MUL, OR
    drv(1'b0, 4'd0, 32'd1, 32'd2, 1'b1);
    @(posedge clk); #1;
    chk("b2b ADD", 64'(bus32.result), 64'd3);
    chk("b2b in_ready in DONE", 64'(bus32.in_ready), 64'd1);
    drv(1'b0, 4'd2, 32'hF0, 32'h3C, 1'b1);
    @(posedge clk); #1;
    chk("b2b AND", 64'(bus32.result), 64'h30);
    chk("b2b AND valid", 64'(bus32.out_valid), 64'd1);
    drv(1'b0, 4'd10, 32'd3, 32'd5, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 4'd3, 32'h0F, 32'hF0, 1'b1);
    begin
      int lat;
      bit low;
      lat = 0;
      low = 1'b1;
      while (!bus32.out_valid && lat < 200) begin
        if (bus32.in_ready) low = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      chk("b2b MUL latency", 64'(lat), 64'd32);
      chk("b2b MUL stall", 64'(low), 64'd1);
    end
    chk("b2b MUL", 64'(bus32.result), 64'd15);
    @(posedge clk); #1;
    drv(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("b2b OR", 64'(bus32.result), 64'hFF);
    chk("b2b OR valid", 64'(bus32.out_valid), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a multiply aborts it
    drv(1'b0, 4'd10, 32'd7, 32'd9, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", 64'(bus32.in_ready), 64'd0);
    chk("mid rst out_valid", 64'(bus32.out_valid), 64'd0);
    chk("mid rst result", 64'(bus32.result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after rst in_ready", 64'(bus32.in_ready), 64'd1);
    chk("after rst out_valid", 64'(bus32.out_valid), 64'd0);

    // WIDTH = 8
    run_op("W8 MUL", 1'b1, 4'd10, 32'hFF, 32'hFF, 8, 32'h01, 1'b0);
    run_op("W8 MULHU", 1'b1, 4'd11, 32'hFF, 32'hFF, 8, 32'hFE, 1'b0);
    run_op("W8 DIVU", 1'b1, 4'd12, 32'd200, 32'd7, 8, 32'd28, 1'b0);
    run_op("W8 REMU", 1'b1, 4'd13, 32'd200, 32'd7, 8, 32'd4, 1'b0);
    run_op("W8 SRA", 1'b1, 4'd9, 32'h80, 32'h0B, 0, 32'hF0, 1'b0);
    run_op("W8 ADD wrap", 1'b1, 4'd0, 32'hFF, 32'h02, 0, 32'h01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU that replaces the fixed 32-bit, 4-operation combinational ALU in the execute stage. It adds logic, compare and shift operations in one cycle and iterative unsigned multiply/divide. Every operation uses a valid/ready handshake on input and output, so the core's execute stage can stall on long operations. Results are registered, with a zero flag for branch resolution.

## Interface
- `WIDTH`, default 32: operand/result width; a power of two, minimum 8.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B. Shifts use only `b[$clog2(WIDTH)-1:0]`.
- `alu_control`  in  4: operation select (see Operation).
- `in_valid`  in  1: operands and op are valid.
- `in_ready`  out  1: the block accepts the operation this cycle.
- `result`  out  WIDTH: registered result.
- `zero`  out  1: `result == 0`, registered alongside `result`.
- `out_valid`  out  1: `result` and `zero` are valid.
- `out_ready`  in  1: the consumer takes the result this cycle.

## Operation
- Single-cycle codes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLT (signed, result 1 or 0); 6 SLTU (unsigned).
  - 7 SLL; 8 SRL; 9 SRA.
- Multi-cycle codes:
  - 10 MUL: low WIDTH bits of the unsigned 2·WIDTH product.
  - 11 MULHU: high WIDTH bits of that product.
  - 12 DIVU: unsigned quotient.
  - 13 REMU: unsigned remainder.
- Codes 14 and 15 execute as ADD (single-cycle).
- All arithmetic is modulo 2^WIDTH; no overflow or carry outputs.
- Divide by zero: DIVU returns all ones; REMU returns `a`. The operation still takes the full multi-cycle latency.
- Multiply is shift-add and divide is restoring, one bit per cycle. Both use a `$clog2(WIDTH)+1`-bit iteration counter.
- State machine:
  - IDLE: `in_ready`=1. On handshake with a single-cycle op, go to DONE with the result registered. On handshake with a multi-cycle op, capture `a`/`b`, clear the accumulator and counter, and go to BUSY.
  - BUSY: `in_ready`=0. One iteration per cycle. When the counter reaches WIDTH-1, that cycle's edge writes the final `result`/`zero` and goes to DONE.
  - DONE: `out_valid`=1, `in_ready`=`out_ready`.
    - `out_ready`=1 with `in_valid`=1: accept the new op the same cycle (back-to-back), transitioning as from IDLE.
    - `out_ready`=1 with `in_valid`=0: go to IDLE.
    - `out_ready`=0: hold `result`/`zero` stable, go nowhere.
- `a`, `b` and `alu_control` are sampled only on the input handshake edge. Later changes do not affect an operation in flight.

## Timing
- Reset, asynchronous:
  - State becomes IDLE.
  - `result`=0, `zero`=0, `out_valid`=0.
  - `in_ready`=0 while `rst`=1, and 1 on the first cycle after release.
- Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded.
- Single-cycle latency: handshake at edge E0 gives `out_valid`=1 after E0. Sustained throughput is 1 op/cycle while `out_ready`=1.
- Multi-cycle latency: handshake at E0, iterations at E1..E(WIDTH), `out_valid`=1 after E(WIDTH). For WIDTH=32 that is 32 cycles from accept to valid.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`. `out_valid` and `result` are registers.
- `zero` is always consistent with the `result` it accompanies.

## Test plan
- Reset and ADD/SUB:
  - Assert `rst` mid-run, then release → `out_valid`=0, `result`=0, `in_ready`=1.
  - ADD 0x7FFFFFFF+1 → 0x80000000 one cycle later.
  - SUB 5-5 → 0 with `zero`=1.
- Compares and shifts (WIDTH=32):
  - SLT 0xFFFFFFFF,1 → 1; SLTU with the same operands → 0.
  - SRA 0x80000000 by 0x24 (shamt 4) → 0xF8000000.
  - Codes 14 and 15 with a=2, b=3 → 5.
- Multiply:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - MULHU with the same operands → 0xFFFFFFFE.
  - `out_valid` rises exactly 32 cycles after accept; `in_ready`=0 throughout.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. Both with 32-cycle latency.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → `result` stable, `in_ready`=0.
  - Toggle `a` during BUSY → result unaffected.
- Back-to-back:
  - With `out_ready`=1, stream ADD, AND, MUL, OR on consecutive cycles → ADD and AND results on consecutive cycles.
  - MUL stalls the input for 32 cycles; OR follows it immediately.
  - Repeat at WIDTH=8 with MUL 0xFF×0xFF → 0x01 after 8 cycles.
